// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
// Holds the FSM state encoding and the relock counter width.
package pll_seq_pkg;

  localparam int RELOCK_CNT_W = 8;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    DEBOUNCE  = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// sync_2ff: generic 1-bit two-flop synchronizer, sync reset to 0.
// Ports: i_clk, i_rst (active high), i_d (async in), o_q (synced out).
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up/recovery sequencer on the free-running reference clock.
// Ports: clk_i, rst_i, pll_lock_i, restart_i -> pll_rst_o, sys_rst_o,
//   lock_stable_o, fault_o, relock_cnt_o[7:0], state_o[2:0].
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    pll_lock_i,
  input  logic                    restart_i,
  output logic                    pll_rst_o,
  output logic                    sys_rst_o,
  output logic                    lock_stable_o,
  output logic                    fault_o,
  output logic [RELOCK_CNT_W-1:0] relock_cnt_o,
  output logic [2:0]              state_o
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int YW = $clog2(MAX_RETRIES + 1);

  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [YW-1:0] RETRY_MAX = YW'(MAX_RETRIES);

  state_t                  r_state;
  logic [RW-1:0]           r_rst_cnt;
  logic [TW-1:0]           r_to_cnt;
  logic [SW-1:0]           r_stab_cnt;
  logic [YW-1:0]           r_retry;
  logic [RELOCK_CNT_W-1:0] r_relock;

  logic r_pll_rst;
  logic r_sys_rst;
  logic r_stable;
  logic r_fault;

  logic          w_lock_s;
  logic          w_to_hit;
  logic [YW-1:0] w_retry_inc;

  sync_2ff u_lock_sync (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_d   (pll_lock_i),
    .o_q   (w_lock_s)
  );

  assign w_to_hit    = (r_to_cnt == TO_LAST);
  assign w_retry_inc = r_retry + YW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= PLL_RST;
      r_rst_cnt  <= '0;
      r_to_cnt   <= '0;
      r_stab_cnt <= '0;
      r_retry    <= '0;
      r_relock   <= '0;
    end else begin
      unique case (r_state)
        PLL_RST: begin
          // restart_i is ignored here: the pulse runs to completion
          if (r_rst_cnt == RST_LAST) begin
            r_state  <= WAIT_LOCK;
            r_to_cnt <= '0;
          end else begin
            r_rst_cnt <= r_rst_cnt + RW'(1);
          end
        end
        WAIT_LOCK, DEBOUNCE: begin
          if (restart_i) begin
            r_state   <= PLL_RST;
            r_rst_cnt <= '0;
            r_retry   <= '0;
          end else if (w_to_hit) begin
            r_retry   <= w_retry_inc;
            r_rst_cnt <= '0;
            r_state   <= (w_retry_inc == RETRY_MAX) ? FAULT : PLL_RST;
          end else begin
            // timeout is cumulative across chatter, never cleared here
            r_to_cnt <= r_to_cnt + TW'(1);
            if (r_state == WAIT_LOCK) begin
              if (w_lock_s) begin
                r_state    <= DEBOUNCE;
                r_stab_cnt <= '0;
              end
            end else if (!w_lock_s) begin
              r_state    <= WAIT_LOCK;
              r_stab_cnt <= '0;
            end else if (r_stab_cnt == STAB_LAST) begin
              r_state <= RUN;
              r_retry <= '0;
            end else begin
              r_stab_cnt <= r_stab_cnt + SW'(1);
            end
          end
        end
        RUN: begin
          if (restart_i || !w_lock_s) begin
            r_state   <= PLL_RST;
            r_rst_cnt <= '0;
          end
          if (restart_i) r_retry <= '0;
          if (!w_lock_s && (r_relock != '1))
            r_relock <= r_relock + RELOCK_CNT_W'(1);
        end
        FAULT: begin
          if (restart_i) begin
            r_state   <= PLL_RST;
            r_rst_cnt <= '0;
            r_retry   <= '0;
          end
        end
        default: begin
          r_state   <= PLL_RST;
          r_rst_cnt <= '0;
        end
      endcase
    end
  end

  // Output flops decode the current state, so they trail it by a cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_stable  <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_pll_rst <= (r_state == PLL_RST) || (r_state == FAULT);
      r_sys_rst <= (r_state != RUN);
      r_stable  <= (r_state == RUN);
      r_fault   <= (r_state == FAULT);
    end
  end

  assign pll_rst_o     = r_pll_rst;
  assign sys_rst_o     = r_sys_rst;
  assign lock_stable_o = r_stable;
  assign fault_o       = r_fault;
  assign relock_cnt_o  = r_relock;
  assign state_o       = r_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer.
// Expected output snapshots are queued per cycle and checked by a monitor.
module tb_pll_lock_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       pll_lock_i = 1'b0;
  logic       restart_i = 1'b0;
  logic       pll_rst_o;
  logic       sys_rst_o;
  logic       lock_stable_o;
  logic       fault_o;
  logic [7:0] relock_cnt_o;
  logic [2:0] state_o;

  always #5 clk_i = ~clk_i;

  pll_lock_sequencer #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (100),
    .STABLE_CYCLES (10),
    .MAX_RETRIES   (2)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pll_lock_i    (pll_lock_i),
    .restart_i     (restart_i),
    .pll_rst_o     (pll_rst_o),
    .sys_rst_o     (sys_rst_o),
    .lock_stable_o (lock_stable_o),
    .fault_o       (fault_o),
    .relock_cnt_o  (relock_cnt_o),
    .state_o       (state_o)
  );

  typedef struct {
    int         cyc;
    string      name;
    logic [2:0] st;
    logic       pr;
    logic       sr;
    logic       ls;
    logic       ft;
    logic [7:0] rc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_tests++;
      if (e.cyc != cyc ||
          {state_o, pll_rst_o, sys_rst_o, lock_stable_o, fault_o,
           relock_cnt_o} !=
          {e.st, e.pr, e.sr, e.ls, e.ft, e.rc}) begin
        n_fail++;
        $display("FAIL %s @%0d: got st=%0d pll_rst=%b sys_rst=%b stable=%b fault=%b relock=%0d, want @%0d st=%0d pll_rst=%b sys_rst=%b stable=%b fault=%b relock=%0d",
                 e.name, cyc, state_o, pll_rst_o, sys_rst_o,
                 lock_stable_o, fault_o, relock_cnt_o, e.cyc, e.st,
                 e.pr, e.sr, e.ls, e.ft, e.rc);
      end
    end
  end

  task automatic expect_at(input int c, input string nm,
                           input logic [2:0] st, input logic pr,
                           input logic sr, input logic ls,
                           input logic ft, input logic [7:0] rc);
    exp_t e;
    e.cyc = c; e.name = nm; e.st = st; e.pr = pr;
    e.sr = sr; e.ls = ls; e.ft = ft; e.rc = rc;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic wait_stable(input logic v, input string nm);
    int k;
    k = 0;
    while (lock_stable_o !== v && k < 100) begin
      step();
      k++;
    end
    if (lock_stable_o !== v) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: lock_stable_o=%b after 100 cycles, want %b",
               nm, lock_stable_o, v);
    end
  endtask

  // Edge t is the last one sampling rst_i high.
  task automatic do_reset(output int t);
    rst_i = 1'b1;
    step();
    step();
    t = cyc + 1;
    expect_at(t, "reset", 3'd0, 1, 1, 0, 0, 8'd0);
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t1, p, n, c, m, np, t2, t3;

    // clean bring-up, lock first sampled at edge 20
    do_reset(t1);
    expect_at(t1 + 4,  "wait_lock_entry", 3'd1, 1, 1, 0, 0, 8'd0);
    expect_at(t1 + 5,  "pll_rst_release", 3'd1, 0, 1, 0, 0, 8'd0);
    expect_at(t1 + 22, "debounce_entry",  3'd2, 0, 1, 0, 0, 8'd0);
    expect_at(t1 + 32, "run_entry",       3'd3, 0, 1, 0, 0, 8'd0);
    expect_at(t1 + 33, "sys_rst_release", 3'd3, 0, 0, 1, 0, 8'd0);
    wait_to(t1 + 19);
    pll_lock_i = 1'b1;

    // restart in RUN coinciding with synchronized lock loss
    expect_at(t1 + 40, "restart_lockloss", 3'd0, 0, 0, 1, 0, 8'd1);
    expect_at(t1 + 41, "restart_outputs",  3'd0, 1, 1, 0, 0, 8'd1);
    wait_to(t1 + 37);
    pll_lock_i = 1'b0;
    wait_to(t1 + 39);
    restart_i = 1'b1;
    step();
    restart_i = 1'b0;
    p = t1 + 40;
    expect_at(p + 17, "rerun_entry",  3'd3, 0, 1, 0, 0, 8'd1);
    expect_at(p + 18, "rerun_output", 3'd3, 0, 0, 1, 0, 8'd1);
    wait_to(p + 4);
    pll_lock_i = 1'b1;

    // lock loss in RUN: sys_rst_o three cycles after the sampled drop
    n = p + 25;
    expect_at(n + 2, "lockloss_state",  3'd0, 0, 0, 1, 0, 8'd2);
    expect_at(n + 3, "lockloss_sysrst", 3'd0, 1, 1, 0, 0, 8'd2);
    expect_at(n + 6, "reseq_wait_lock", 3'd1, 1, 1, 0, 0, 8'd2);
    expect_at(n + 7, "reseq_pll_rel",   3'd1, 0, 1, 0, 0, 8'd2);
    wait_to(n - 1);
    pll_lock_i = 1'b0;
    wait_to(n + 7);
    pll_lock_i = 1'b1;
    wait_stable(1'b1, "relock_first");

    // 300 more losses: counter saturates
    for (int i = 0; i < 300; i++) begin
      pll_lock_i = 1'b0;
      wait_stable(1'b0, "sat_drop");
      pll_lock_i = 1'b1;
      wait_stable(1'b1, "sat_relock");
    end
    c = cyc;
    expect_at(c + 2, "relock_saturated", 3'd3, 0, 0, 1, 0, 8'd255);
    wait_to(c + 2);

    // one-cycle glitch, then rst_i during DEBOUNCE
    m = cyc + 3;
    np = m + 1;
    expect_at(np + 2,  "glitch_lockloss", 3'd0, 0, 0, 1, 0, 8'd255);
    expect_at(np + 3,  "glitch_sysrst",   3'd0, 1, 1, 0, 0, 8'd255);
    expect_at(np + 9,  "in_debounce",     3'd2, 0, 1, 0, 0, 8'd255);
    expect_at(np + 10, "rst_in_debounce", 3'd0, 1, 1, 0, 0, 8'd0);
    wait_to(m);
    pll_lock_i = 1'b0;
    step();
    pll_lock_i = 1'b1;
    wait_to(np + 9);
    rst_i = 1'b1;
    pll_lock_i = 1'b0;

    // chatter: 5 high, 1 low, then high
    do_reset(t2);
    expect_at(t2 + 16, "chatter_debounce", 3'd2, 0, 1, 0, 0, 8'd0);
    expect_at(t2 + 17, "chatter_drop",     3'd1, 0, 1, 0, 0, 8'd0);
    expect_at(t2 + 18, "chatter_rearm",    3'd2, 0, 1, 0, 0, 8'd0);
    expect_at(t2 + 27, "chatter_not_yet",  3'd2, 0, 1, 0, 0, 8'd0);
    expect_at(t2 + 28, "chatter_run",      3'd3, 0, 1, 0, 0, 8'd0);
    expect_at(t2 + 29, "chatter_release",  3'd3, 0, 0, 1, 0, 8'd0);
    wait_to(t2 + 9);
    pll_lock_i = 1'b1;
    wait_to(t2 + 14);
    pll_lock_i = 1'b0;
    wait_to(t2 + 15);
    pll_lock_i = 1'b1;
    wait_to(t2 + 30);
    pll_lock_i = 1'b0;

    // chatter near the cumulative timeout, then no-lock to FAULT
    do_reset(t3);
    expect_at(t3 + 103, "to_debounce",     3'd2, 0, 1, 0, 0, 8'd0);
    expect_at(t3 + 104, "to_retry",        3'd0, 0, 1, 0, 0, 8'd0);
    expect_at(t3 + 105, "to_pll_pulse",    3'd0, 1, 1, 0, 0, 8'd0);
    expect_at(t3 + 108, "to_wait_lock",    3'd1, 1, 1, 0, 0, 8'd0);
    expect_at(t3 + 109, "to_debounce2",    3'd2, 0, 1, 0, 0, 8'd0);
    expect_at(t3 + 119, "to_run",          3'd3, 0, 1, 0, 0, 8'd0);
    expect_at(t3 + 120, "to_run_out",      3'd3, 0, 0, 1, 0, 8'd0);
    expect_at(t3 + 127, "nl_lockloss",     3'd0, 0, 0, 1, 0, 8'd1);
    expect_at(t3 + 128, "nl_pll_rst",      3'd0, 1, 1, 0, 0, 8'd1);
    expect_at(t3 + 231, "nl_timeout1",     3'd0, 0, 1, 0, 0, 8'd1);
    expect_at(t3 + 232, "nl_pulse1",       3'd0, 1, 1, 0, 0, 8'd1);
    expect_at(t3 + 335, "nl_fault_state",  3'd4, 0, 1, 0, 0, 8'd1);
    expect_at(t3 + 336, "nl_fault_out",    3'd4, 1, 1, 0, 1, 8'd1);
    expect_at(t3 + 339, "fault_holds",     3'd4, 1, 1, 0, 1, 8'd1);
    expect_at(t3 + 340, "fault_restart",   3'd0, 1, 1, 0, 1, 8'd1);
    expect_at(t3 + 341, "fault_cleared",   3'd0, 1, 1, 0, 0, 8'd1);
    expect_at(t3 + 343, "pllrst_ignore",   3'd0, 1, 1, 0, 0, 8'd1);
    expect_at(t3 + 344, "pllrst_on_time",  3'd1, 1, 1, 0, 0, 8'd1);
    expect_at(t3 + 345, "pllrst_release",  3'd1, 0, 1, 0, 0, 8'd1);
    expect_at(t3 + 444, "retry_cleared",   3'd0, 0, 1, 0, 0, 8'd1);
    expect_at(t3 + 548, "fault_again",     3'd4, 0, 1, 0, 0, 8'd1);
    expect_at(t3 + 549, "fault_again_out", 3'd4, 1, 1, 0, 1, 8'd1);
    expect_at(t3 + 555, "rst_in_fault",    3'd0, 1, 1, 0, 0, 8'd0);
    wait_to(t3 + 92);
    pll_lock_i = 1'b1;
    wait_to(t3 + 97);
    pll_lock_i = 1'b0;
    wait_to(t3 + 98);
    pll_lock_i = 1'b1;
    wait_to(t3 + 124);
    pll_lock_i = 1'b0;
    wait_to(t3 + 339);
    restart_i = 1'b1;
    step();
    restart_i = 1'b0;
    wait_to(t3 + 341);
    restart_i = 1'b1;
    step();
    restart_i = 1'b0;
    wait_to(t3 + 554);
    rst_i = 1'b1;
    step();
    wait_to(t3 + 560);

    for (int k = 0; k < 10 && q.size() > 0; k++) step();
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checkpoints left, want 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
